dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back, write-allocate L1 data cache between the pipeline MEM stage and the 256-bit-line data memory. Serves 32-bit word loads/stores in one cycle on a hit; on a miss it stalls the pipeline, writes back a dirty victim line, refills the line from memory, then completes the access.

## Interface
- NUM_SETS, 16, number of lines; power of two.
- LINE_W, 256, line width in bits (8 words, 32 bytes).
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- cpu_req_i  in  1  access request (load or store)
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address; bits [1:0] ignored (word accesses only)
- cpu_wdata_i  in  32  store data
- cpu_rdata_o  out  32  load data, valid when cpu_req_i & !cpu_we_i & !cpu_stall_o
- cpu_stall_o  out  1  pipeline stall
- mem_enable_o  out  1  memory request, held until mem_ack_i
- mem_write_o  out  1  1 = line write-back
- mem_addr_o  out  32  line address, bits [4:0] = 0
- mem_data_o  out  256  write-back line
- mem_ack_i  in  1  one-cycle completion pulse from memory
- mem_data_i  in  256  refill line, valid the cycle after mem_ack_i

## Operation
- Address split (defaults): offset [4:0], word select [4:2], index [8:5], tag [31:9] (23 bits).
- Per line: valid, dirty, tag, 256-bit data.
- States: IDLE, WRITEBACK, ALLOCATE, REFILL.
- IDLE: hit = cpu_req_i & valid[idx] & tag match. Load hit: cpu_rdata_o = selected word, combinational. Store hit: word updated and dirty set at clock edge. Miss: cpu_stall_o = 1 combinationally, mem_enable_o <= 1, next state WRITEBACK if victim valid & dirty, else ALLOCATE.
- WRITEBACK: mem_write_o = 1, mem_addr_o = {victim tag, idx, 5'b0}, mem_data_o = victim line. On mem_ack_i: switch to ALLOCATE; mem_enable_o stays 1, mem_write_o drops to 0.
- ALLOCATE: mem_write_o = 0, mem_addr_o = {req tag, idx, 5'b0}. On mem_ack_i: mem_enable_o <= 0, go to REFILL.
- REFILL: write mem_data_i into line, set tag, valid = 1, dirty = 0; go to IDLE. The replayed access then hits (store hit sets dirty).
- cpu_stall_o = 1 in WRITEBACK, ALLOCATE and REFILL, and in IDLE on a miss.
- CPU holds request, address and data stable while cpu_stall_o = 1; a change is not supported.
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- Reset (any state, mid-miss included): state IDLE, all valid/dirty cleared, mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0. cpu_rdata_o = 0 and cpu_stall_o = 0 while rst_i is high. Tag and data arrays are not reset. An in-flight memory transaction is abandoned.

## Timing
- Hit latency: 0 extra cycles; no stall.
- mem_enable_o and mem_write_o are registered. mem_enable_o is low in the cycle after the final ack, so the memory does not restart.
- With the standard memory (ack 9 cycles after enable is first sampled):
  - Clean miss: stall for 12 cycles; access completes in cycle 12 after the miss cycle.
  - Dirty miss: stall for 22 cycles.
- The array is written at the clock edge. A store hit followed by a load to the same word in the next cycle returns the new data.

## Structure
- Package dcache_pkg:
  - state enum (IDLE, WRITEBACK, ALLOCATE, REFILL)
  - localparams for offset, index and tag widths derived from NUM_SETS and LINE_W
  - line-address helper constants
- Sub-module dcache_sram: valid/dirty/tag/data arrays.
  - One asynchronous read port (index).
  - One synchronous write port with whole-line or single-word enable.
  - Valid and dirty bits cleared by rst_i.
- The controller FSM and hit logic stay in dcache_ctrl.

## Test plan
- After reset, load from 0x0000_0040 → stall 12 cycles, mem_enable_o with mem_write_o = 0 and mem_addr_o = 0x40; rdata equals memory word 0.
- Store 0xDEADBEEF to 0x44 (hit), then load 0x44 → no stall; rdata = 0xDEADBEEF.
- Load 0x0000_0240 (same index, new tag) → write-back to 0x40 carrying 0xDEADBEEF in word 1, then refill from 0x240; stall 22 cycles.
- Back-to-back loads to all 8 words of one line after a refill → zero stall cycles.
- Assert rst_i during ALLOCATE → mem_enable_o = 0 immediately; next load to the same address misses again.
- Load miss on a clean victim → no write-back transaction, exactly one mem_enable_o assertion.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped L1 data cache.
// Widths are derived from the set count and line width so the cache can be resized.
package dcache_pkg;

  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int WORD_OFF_W = 2;

  function automatic int dc_off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int dc_idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int dc_tag_w(input int num_sets, input int line_w);
    return ADDR_W - dc_off_w(line_w) - dc_idx_w(num_sets);
  endfunction

  // Clears the byte-offset bits of an address to give its line address.
  function automatic logic [ADDR_W-1:0] dc_line_mask(input int line_w);
    logic [ADDR_W-1:0] off_bits;
    off_bits = ADDR_W'(line_w / 8 - 1);
    return ~off_bits;
  endfunction

  localparam int DC_NUM_SETS = 16;
  localparam int DC_LINE_W   = 256;
  localparam int DC_OFF_W    = dc_off_w(DC_LINE_W);
  localparam int DC_IDX_W    = dc_idx_w(DC_NUM_SETS);
  localparam int DC_TAG_W    = dc_tag_w(DC_NUM_SETS, DC_LINE_W);
  localparam int DC_WSEL_W   = DC_OFF_W - WORD_OFF_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE,
    S_REFILL
  } state_e;

endpackage

// File: rtl/dcache_sram.sv
// Valid/dirty/tag/data storage: asynchronous read by index, one synchronous write port.
// A line write (refill) marks the line valid and clean; a word write (store hit) marks it dirty.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = DC_NUM_SETS,
  parameter int LINE_W   = DC_LINE_W,
  parameter int IDX_W    = DC_IDX_W,
  parameter int TAG_W    = DC_TAG_W,
  parameter int WSEL_W   = DC_WSEL_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  i_idx,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [TAG_W-1:0]  o_tag,
  output logic [LINE_W-1:0] o_line,
  input  logic              i_line_we,
  input  logic [TAG_W-1:0]  i_line_tag,
  input  logic [LINE_W-1:0] i_line_data,
  input  logic              i_word_we,
  input  logic [WSEL_W-1:0] i_wsel,
  input  logic [WORD_W-1:0] i_word_data
);

  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [LINE_W-1:0]   r_data [NUM_SETS];

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_line  = r_data[i_idx];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_line_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_word_we) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (i_line_we) begin
      r_tag[i_idx]  <= i_line_tag;
      r_data[i_idx] <= i_line_data;
    end else if (i_word_we) begin
      r_data[i_idx][i_wsel*WORD_W +: WORD_W] <= i_word_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate L1 data cache controller.
// Hits complete combinationally; misses stall, write back a dirty victim, refill, then replay.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = DC_NUM_SETS,
  parameter int LINE_W   = DC_LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_wdata_i,
  output logic [WORD_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i
);

  localparam int OFF_W  = dc_off_w(LINE_W);
  localparam int IDX_W  = dc_idx_w(NUM_SETS);
  localparam int TAG_W  = dc_tag_w(NUM_SETS, LINE_W);
  localparam int WSEL_W = OFF_W - WORD_OFF_W;

  state_e            r_state, w_state_nxt;
  logic              r_mem_enable, w_mem_enable_nxt;
  logic              r_mem_write, w_mem_write_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [LINE_W-1:0] r_mem_data, w_mem_data_nxt;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [WSEL_W-1:0] w_wsel;
  logic [ADDR_W-1:0] w_req_line;
  logic              w_valid, w_dirty;
  logic [TAG_W-1:0]  w_vtag;
  logic [LINE_W-1:0] w_line;
  logic              w_hit, w_miss, w_line_we, w_word_we;
  logic              w_unused_addr;

  assign w_idx         = cpu_addr_i[OFF_W +: IDX_W];
  assign w_tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign w_wsel        = cpu_addr_i[WORD_OFF_W +: WSEL_W];
  assign w_req_line    = cpu_addr_i & dc_line_mask(LINE_W);
  assign w_unused_addr = ^cpu_addr_i[WORD_OFF_W-1:0];

  dcache_sram #(
    .NUM_SETS (NUM_SETS),
    .LINE_W   (LINE_W),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W),
    .WSEL_W   (WSEL_W)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_idx       (w_idx),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_vtag),
    .o_line      (w_line),
    .i_line_we   (w_line_we),
    .i_line_tag  (w_tag),
    .i_line_data (mem_data_i),
    .i_word_we   (w_word_we),
    .i_wsel      (w_wsel),
    .i_word_data (cpu_wdata_i)
  );

  // The victim is read through the request index, which the CPU holds stable during a miss.
  assign w_hit     = !rst_i && cpu_req_i && w_valid && (w_vtag == w_tag);
  assign w_miss    = !rst_i && cpu_req_i && !w_hit;
  assign w_word_we = (r_state == S_IDLE) && w_hit && cpu_we_i;
  assign w_line_we = (r_state == S_REFILL);

  assign cpu_rdata_o = ((r_state == S_IDLE) && w_hit) ? w_line[w_wsel*WORD_W +: WORD_W] : '0;
  assign cpu_stall_o = !rst_i && ((r_state != S_IDLE) || w_miss);

  always_comb begin
    w_state_nxt      = r_state;
    w_mem_enable_nxt = r_mem_enable;
    w_mem_write_nxt  = r_mem_write;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_data_nxt   = r_mem_data;
    case (r_state)
      S_IDLE: begin
        if (w_miss) begin
          w_mem_enable_nxt = 1'b1;
          if (w_valid && w_dirty) begin
            w_state_nxt     = S_WRITEBACK;
            w_mem_write_nxt = 1'b1;
            w_mem_addr_nxt  = {w_vtag, w_idx, {OFF_W{1'b0}}};
            w_mem_data_nxt  = w_line;
          end else begin
            w_state_nxt     = S_ALLOCATE;
            w_mem_write_nxt = 1'b0;
            w_mem_addr_nxt  = w_req_line;
          end
        end
      end
      // Enable stays high across the write-back to refill hand-off.
      S_WRITEBACK: begin
        if (mem_ack_i) begin
          w_state_nxt     = S_ALLOCATE;
          w_mem_write_nxt = 1'b0;
          w_mem_addr_nxt  = w_req_line;
        end
      end
      S_ALLOCATE: begin
        if (mem_ack_i) begin
          w_state_nxt      = S_REFILL;
          w_mem_enable_nxt = 1'b0;
        end
      end
      S_REFILL: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_enable <= w_mem_enable_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_data   <= w_mem_data_nxt;
    end
  end

  assign mem_enable_o = r_mem_enable;
  assign mem_write_o  = r_mem_write;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios plus random traffic against a cache/memory reference model.
// A memory model acks 9 cycles after it first samples mem_enable_o.
module tb_dcache_ctrl;

  localparam int NSETS  = 16;
  localparam int ACK_AT = 10;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [255:0] data;
  } txn_t;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         cpu_req_i = 1'b0;
  logic         cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = '0;
  logic [31:0]  cpu_wdata_i = '0;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_ack_i = 1'b0;
  logic [255:0] mem_data_i = '0;

  int n_cmp = 0;
  int n_bad = 0;

  dcache_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  // Memory attached to the DUT
  logic [255:0] env_mem [logic [31:0]];
  txn_t         txq[$];
  int           env_cnt = 0;
  int           env_rises = 0;
  logic         env_en_q = 1'b0;
  logic         env_pend_vld = 1'b0;
  logic [255:0] env_pending = '0;

  function automatic logic [255:0] env_line(input logic [31:0] la);
    logic [255:0] l;
    if (env_mem.exists(la)) return env_mem[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(4 * w));
    return l;
  endfunction

  always @(negedge clk_i) begin
    mem_data_i   = env_pend_vld ? env_pending : {8{32'hBAD0_BAD0}};
    env_pend_vld = 1'b0;
    mem_ack_i    = 1'b0;
    if (mem_enable_o && !rst_i) begin
      env_cnt++;
      if (!env_en_q) env_rises++;
      if (env_cnt == ACK_AT) begin
        mem_ack_i = 1'b1;
        env_cnt   = 0;
        if (mem_write_o) env_mem[mem_addr_o] = mem_data_o;
        else begin
          env_pending  = env_line(mem_addr_o);
          env_pend_vld = 1'b1;
        end
        txq.push_back('{mem_write_o, mem_addr_o, mem_data_o});
      end
    end else begin
      env_cnt = 0;
    end
    env_en_q = mem_enable_o;
  end

  // Reference model: cache contents and the backing store the cache should leave behind
  logic        m_valid [NSETS];
  logic        m_dirty [NSETS];
  int          m_tag   [NSETS];
  logic [31:0] m_data  [NSETS][8];
  logic [31:0] m_mem   [logic [31:0]];

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return m_mem.exists(a) ? m_mem[a] : init_word(a);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < NSETS; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one access starting at a falling edge, returns at the falling edge after completion.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd);
    int           idx, tg, w, stalls, exp_stall, rises0;
    logic [31:0]  base, vbase, exp_rd;
    logic [255:0] vline;
    txn_t         exp_q[$];
    idx  = int'((a / 32) % NSETS);
    tg   = int'(a / (32 * NSETS));
    w    = int'((a / 4) % 8);
    base = a & ~32'h1F;
    exp_stall = 0;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        vbase = 32'(m_tag[idx] * 32 * NSETS + idx * 32);
        for (int k = 0; k < 8; k++) begin
          vline[k*32 +: 32] = m_data[idx][k];
          m_mem[vbase + 32'(4 * k)] = m_data[idx][k];
        end
        exp_q.push_back('{1'b1, vbase, vline});
        exp_stall = 22;
      end else begin
        exp_stall = 12;
      end
      exp_q.push_back('{1'b0, base, '0});
      for (int k = 0; k < 8; k++) m_data[idx][k] = ref_word(base + 32'(4 * k));
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
    end
    exp_rd = m_data[idx][w];
    if (we) begin
      m_data[idx][w] = wd;
      m_dirty[idx]   = 1'b1;
    end

    txq.delete();
    rises0      = env_rises;
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = a;
    cpu_wdata_i = wd;
    #1;
    stalls = 0;
    while (cpu_stall_o && stalls < 100) begin
      @(negedge clk_i);
      #1;
      stalls++;
    end
    chk("stall_cycles", 256'(stalls), 256'(exp_stall));
    if (!we) chk("load_rdata", 256'(cpu_rdata_o), 256'(exp_rd));
    chk("enable_assertions", 256'(env_rises - rises0), 256'(exp_q.size() > 0 ? 1 : 0));
    chk("txn_count", 256'(txq.size()), 256'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < txq.size(); i++) begin
      chk("txn_write", 256'(txq[i].wr), 256'(exp_q[i].wr));
      chk("txn_addr", 256'(txq[i].addr), 256'(exp_q[i].addr));
      if (exp_q[i].wr) chk("txn_wb_data", txq[i].data, exp_q[i].data);
    end
    @(negedge clk_i);
  endtask

  initial begin
    logic [31:0] ra, rd;
    model_reset();

    // Reset with a request pending: everything quiet
    #1;
    rst_i      = 1'b1;
    cpu_req_i  = 1'b1;
    cpu_addr_i = 32'h40;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_stall", 256'(cpu_stall_o), 256'(0));
    chk("rst_rdata", 256'(cpu_rdata_o), 256'(0));
    chk("rst_enable", 256'(mem_enable_o), 256'(0));
    chk("rst_write", 256'(mem_write_o), 256'(0));
    chk("rst_addr", 256'(mem_addr_o), 256'(0));
    chk("rst_data", mem_data_o, 256'(0));
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Cold miss, then store hit and immediate load
    access(1'b0, 32'h40, '0);
    chk("cold_rdata_word0", 256'(cpu_rdata_o), 256'(init_word(32'h40)));
    access(1'b1, 32'h44, 32'hDEAD_BEEF);
    access(1'b0, 32'h44, '0);
    chk("store_then_load", 256'(cpu_rdata_o), 256'(32'hDEAD_BEEF));

    // Conflict miss on the dirty line
    access(1'b0, 32'h240, '0);
    if (txq.size() > 0) chk("wb_word1", 256'(txq[0].data[63:32]), 256'(32'hDEAD_BEEF));

    // Whole line streamed back to back
    for (int k = 0; k < 8; k++) access(1'b0, 32'h240 + 32'(4 * k), '0);

    // Reset in the middle of a refill
    txq.delete();
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h1A0;
    repeat (4) @(negedge clk_i);
    #1;
    chk("alloc_enable", 256'(mem_enable_o), 256'(1));
    chk("alloc_write", 256'(mem_write_o), 256'(0));
    rst_i = 1'b1;
    #1;
    chk("midmiss_rst_enable", 256'(mem_enable_o), 256'(0));
    chk("midmiss_rst_stall", 256'(cpu_stall_o), 256'(0));
    chk("midmiss_rst_addr", 256'(mem_addr_o), 256'(0));
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    chk("midmiss_no_txn", 256'(txq.size()), 256'(0));
    @(negedge clk_i);
    access(1'b0, 32'h1A0, '0);

    // Clean victim replaced without write-back
    access(1'b0, 32'h3A0, '0);

    // Random traffic over a few sets and tags
    for (int n = 0; n < 160; n++) begin
      ra = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
      rd = $urandom;
      access(($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0, ra, rd);
      if ($urandom_range(0, 3) == 0) begin
        cpu_req_i = 1'b0;
        #1;
        chk("idle_no_stall", 256'(cpu_stall_o), 256'(0));
        @(negedge clk_i);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
